lfsr_req_arbiter: RTL and testbench
===================================

Name: lfsr_req_arbiter

Overview:
- Controller that shares one 16-bit Galois LFSR pseudo-random source between two requesters.
- It owns the LFSR register and sequences seeding, stepping, and word delivery. It arbitrates round-robin between requesters and prevents the all-zero lockup state.
- Sits between the PRNG datapath and its consumer blocks.

Parameters:
SEED, 16'hACE1, LFSR value after reset and replacement value for an illegal zero seed.
STEPS, 16, LFSR shifts per delivered word; legal range 1..255; 8-bit step counter.

Ports:
CLK  input  1  clock; all state updates on rising edge.
n_RESET  input  1  asynchronous active-low reset.
req  input  2  level request per requester; bit i = requester i.
seed_load  input  1  load seed_in into LFSR; honoured only in IDLE.
seed_in  input  16  new seed value.
rnd_ack  input  1  consumer accepts rnd_out; honoured only in DELIVER.
gnt  output  2  one-hot grant, held for the whole transaction.
rnd_out  output  16  delivered random word.
rnd_valid  output  1  rnd_out valid.
busy  output  1  high in SHIFT or DELIVER.
seed_err  output  1  one-cycle pulse: zero seed was replaced by SEED.

Behaviour:
- LFSR step: fb = L[0]; L_next = {1'b0, L[15:1]} ^ (fb ? 16'hB400 : 16'h0000).
  - Polynomial is x^16+x^14+x^13+x^11+1, maximal length, period 65535.
  - L never holds 0.
- Reset (async, n_RESET=0):
  - State = IDLE, L = SEED, gnt = 0, rnd_out = 0, rnd_valid = 0, busy = 0, seed_err = 0.
  - Round-robin pointer = 0 (requester 0 preferred); step counter = 0.
  - Reset asserted mid-transaction discards it; nothing resumes.
- States: IDLE, SHIFT, DELIVER.
- IDLE:
  - seed_load=1 takes priority over req in the same cycle.
  - L <= seed_in, or SEED with seed_err=1 for one cycle if seed_in==0. State stays IDLE.
  - Pending req stays pending and is arbitrated next cycle.
  - Otherwise, if req != 0:
    - Winner = preferred requester if its req is set, else the other.
    - gnt <= onehot(winner), counter <= STEPS, busy <= 1, state <= SHIFT.
- SHIFT:
  - Each edge: L steps once and counter decrements.
  - On the edge where counter goes 1->0: state <= DELIVER, rnd_out <= stepped L, rnd_valid <= 1.
  - Exactly STEPS shifts per word.
- DELIVER:
  - rnd_out and rnd_valid are held stable; L frozen.
  - rnd_ack=1: on that edge rnd_valid <= 0, gnt <= 0, busy <= 0, pointer <= other requester (non-winner), state <= IDLE.
  - rnd_ack in IDLE or SHIFT is ignored.
- Latency:
  - req sampled at edge t -> gnt high after t.
  - rnd_valid high after edge t+STEPS.
  - After ack at edge a, a new grant is possible at edge a+1 (one IDLE cycle minimum).
- Dropping req after grant does not abort; the transaction completes and requires rnd_ack.
- seed_load while busy=1 is ignored (not queued).
- rnd_out keeps its last delivered value after ack until the next delivery.
- Both requesters continuously active: grants strictly alternate 0,1,0,1...
- A single active requester is granted on every transaction regardless of pointer.

Test Plan:
1. Reset, then req=01, STEPS=1 override, ack on first rnd_valid -> gnt=01, rnd_out=16'hE270; next transaction rnd_out=16'h7138; seed_err stays 0.
2. Default STEPS=16, req=01 at edge t -> rnd_valid rises after edge t+16; rnd_out matches the bench reference model after 16 steps from 16'hACE1; rnd_out stable until rnd_ack.
3. req=11 held, four transactions with immediate ack -> gnt sequence 01,10,01,10; each word equals the next STEPS-step model value, no repeats or skips.
4. seed_load=1 with seed_in=0 and req=01 in the same IDLE cycle -> L=16'hACE1, seed_err pulses one cycle, gnt=01 on the following edge. seed_in=16'h0001 with STEPS=1 -> rnd_out=16'hB400.
5. seed_load during SHIFT with seed_in=16'h1234 -> ignored; delivered word follows the unseeded sequence; busy=1 throughout.
6. n_RESET pulsed low during SHIFT -> gnt, rnd_valid, busy drop asynchronously; after release, first STEPS=1 word is 16'hE270 and requester 0 has priority.

Source files
------------

// File: rtl/lfsr_req_arbiter.sv
// Two-requester round-robin front end for a shared 16-bit Galois LFSR.
// Each grant runs STEPS shifts, then holds the word until the consumer acks.
module lfsr_req_arbiter #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int unsigned STEPS = 16
) (
  input  logic        CLK,
  input  logic        n_RESET,
  input  logic [1:0]  req,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic        rnd_ack,
  output logic [1:0]  gnt,
  output logic [15:0] rnd_out,
  output logic        rnd_valid,
  output logic        busy,
  output logic        seed_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DELIVER} state_e;

  localparam logic [7:0] STEPS_C = 8'(STEPS);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [15:0] rnd_q, rnd_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        win;
  logic [15:0] lfsr_step;

  // Right-shift Galois form of x^16+x^14+x^13+x^11+1; a nonzero state never reaches zero.
  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= 8'd0;
      ptr_q   <= 1'b0;
      gnt_q   <= 2'b00;
      rnd_q   <= 16'h0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    rnd_d   = rnd_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    win     = req[ptr_q] ? ptr_q : ~ptr_q;

    case (state_q)
      IDLE: begin
        if (seed_load) begin
          if (seed_in == 16'h0000) begin
            lfsr_d = SEED;
            err_d  = 1'b1;
          end else begin
            lfsr_d = seed_in;
          end
        end else if (req != 2'b00) begin
          gnt_d   = win ? 2'b10 : 2'b01;
          cnt_d   = STEPS_C;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        lfsr_d = lfsr_step;
        cnt_d  = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          rnd_d   = lfsr_step;
          valid_d = 1'b1;
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        if (rnd_ack) begin
          valid_d = 1'b0;
          gnt_d   = 2'b00;
          // Hand preference to whichever requester did not win this round.
          ptr_d   = gnt_q[0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt       = gnt_q;
  assign rnd_out   = rnd_q;
  assign rnd_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign seed_err  = err_q;

endmodule

// File: tb/tb_lfsr_req_arbiter.sv
// Directed bench: a STEPS=1 and a default STEPS=16 instance share stimulus;
// expected words are queued at request time and popped when rnd_valid appears.
module tb_lfsr_req_arbiter;

  logic        CLK;
  logic        n_RESET;
  logic [1:0]  req;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        rnd_ack;

  logic [1:0]  gnt1, gnt16;
  logic [15:0] rnd1, rnd16;
  logic        valid1, valid16, busy1, busy16, err1, err16;

  logic        sel;  // 0: observe STEPS=1 instance, 1: observe STEPS=16 instance
  logic [1:0]  o_gnt;
  logic [15:0] o_rnd;
  logic        o_valid, o_busy, o_err;

  int          n_cmp;
  int          n_mis;
  logic [15:0] m_lfsr;
  logic [15:0] exp_q[$];

  lfsr_req_arbiter #(.SEED(16'hACE1), .STEPS(1)) u_dut1 (
    .CLK(CLK), .n_RESET(n_RESET), .req(req), .seed_load(seed_load),
    .seed_in(seed_in), .rnd_ack(rnd_ack), .gnt(gnt1), .rnd_out(rnd1),
    .rnd_valid(valid1), .busy(busy1), .seed_err(err1)
  );

  lfsr_req_arbiter u_dut16 (
    .CLK(CLK), .n_RESET(n_RESET), .req(req), .seed_load(seed_load),
    .seed_in(seed_in), .rnd_ack(rnd_ack), .gnt(gnt16), .rnd_out(rnd16),
    .rnd_valid(valid16), .busy(busy16), .seed_err(err16)
  );

  assign o_gnt   = sel ? gnt16   : gnt1;
  assign o_rnd   = sel ? rnd16   : rnd1;
  assign o_valid = sel ? valid16 : valid1;
  assign o_busy  = sel ? busy16  : busy1;
  assign o_err   = sel ? err16   : err1;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] model_step(input logic [15:0] l);
    logic [15:0] n;
    n = {1'b0, l[15:1]};
    if (l[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    n_RESET   = 1'b0;
    req       = 2'b00;
    seed_load = 1'b0;
    seed_in   = 16'h0000;
    rnd_ack   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_RESET = 1'b1;
    m_lfsr  = 16'hACE1;
    exp_q.delete();
  endtask

  task automatic txn(input logic [1:0] r, input logic [1:0] exp_g, input int hold, input bit inject);
    int          n;
    int          cyc;
    logic [15:0] w;
    n = sel ? 16 : 1;
    for (int i = 0; i < n; i++) m_lfsr = model_step(m_lfsr);
    exp_q.push_back(m_lfsr);

    req = r;
    @(posedge CLK); #1;
    check("gnt", 32'(o_gnt), 32'(exp_g));
    check("busy_grant", 32'(o_busy), 32'd1);

    cyc = 0;
    while (!o_valid && cyc < 300) begin
      if (inject && cyc == 2) begin
        seed_load = 1'b1;
        seed_in   = 16'h1234;
      end else begin
        seed_load = 1'b0;
      end
      @(posedge CLK); #1;
      cyc++;
      if (!o_valid) check("busy_shift", 32'(o_busy), 32'd1);
    end
    seed_load = 1'b0;
    check("latency", 32'(cyc), 32'(n));

    w = exp_q.pop_front();
    check("rnd_out", 32'(o_rnd), 32'(w));
    check("gnt_hold", 32'(o_gnt), 32'(exp_g));
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_rnd", 32'(o_rnd), 32'(w));
    end

    rnd_ack = 1'b1;
    @(posedge CLK); #1;
    rnd_ack = 1'b0;
    check("ack_valid", 32'(o_valid), 32'd0);
    check("ack_gnt", 32'(o_gnt), 32'd0);
    check("ack_busy", 32'(o_busy), 32'd0);
    check("ack_rnd_kept", 32'(o_rnd), 32'(w));
    check("seed_err_quiet", 32'(o_err), 32'd0);
    $display("txn req=%b gnt=%b word=%h latency=%0d", r, exp_g, w, cyc);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    sel   = 1'b0;
    do_reset();

    // Reset state and first STEPS=1 words from the default seed
    check("rst_gnt", 32'(o_gnt), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_rnd", 32'(o_rnd), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    txn(2'b01, 2'b01, 0, 1'b0);
    check("first_word_const", 32'(rnd1), 32'h0000E270);
    txn(2'b01, 2'b01, 0, 1'b0);
    check("second_word_const", 32'(rnd1), 32'h00007138);

    // Zero seed with a simultaneous request: seed wins, request waits a cycle
    seed_load = 1'b1;
    seed_in   = 16'h0000;
    req       = 2'b01;
    @(posedge CLK); #1;
    seed_load = 1'b0;
    check("zero_seed_err", 32'(o_err), 32'd1);
    check("zero_seed_nogrant", 32'(o_gnt), 32'd0);
    check("zero_seed_idle", 32'(o_busy), 32'd0);
    m_lfsr = 16'hACE1;
    txn(2'b01, 2'b01, 0, 1'b0);
    check("zero_seed_word", 32'(rnd1), 32'h0000E270);

    req       = 2'b00;
    seed_load = 1'b1;
    seed_in   = 16'h0001;
    @(posedge CLK); #1;
    seed_load = 1'b0;
    check("seed1_no_err", 32'(o_err), 32'd0);
    m_lfsr = 16'h0001;
    txn(2'b01, 2'b01, 0, 1'b0);
    check("seed1_word", 32'(rnd1), 32'h0000B400);

    // Default STEPS=16: latency and hold-until-ack
    sel = 1'b1;
    do_reset();
    txn(2'b01, 2'b01, 3, 1'b0);

    // Both requesting: strict alternation starting at requester 0
    do_reset();
    txn(2'b11, 2'b01, 0, 1'b0);
    txn(2'b11, 2'b10, 0, 1'b0);
    txn(2'b11, 2'b01, 0, 1'b0);
    txn(2'b11, 2'b10, 0, 1'b0);

    // Seed load mid-SHIFT must not disturb the sequence
    txn(2'b01, 2'b01, 0, 1'b1);

    // Asynchronous reset in the middle of SHIFT
    req = 2'b01;
    @(posedge CLK); #1;
    check("pre_rst_gnt", 32'(o_gnt), 32'd1);
    @(posedge CLK); #3;
    n_RESET = 1'b0;
    #1;
    check("async_gnt", 32'(o_gnt), 32'd0);
    check("async_valid", 32'(o_valid), 32'd0);
    check("async_busy", 32'(o_busy), 32'd0);
    req = 2'b00;
    @(posedge CLK); #1;
    n_RESET = 1'b1;
    m_lfsr  = 16'hACE1;
    exp_q.delete();
    sel = 1'b0;
    txn(2'b11, 2'b01, 0, 1'b0);
    check("post_rst_word", 32'(rnd1), 32'h0000E270);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
